multicycle_ctrl_fsm: RTL and testbench

Multi-cycle main controller for the MIPS-subset datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, over a single shared ALU and a single unified memory port with a ready handshake. It replaces the single-cycle opcode decoder when the CPU is built as a multi-cycle core. ALU_op encodings are the same as those consumed by the existing ALU control.

---
 rtl/multicycle_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main controller for the MIPS-subset datapath: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and a unified ready-handshake memory port.
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [3:0] alu_op_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] pc_src_o,
    output logic       branch_o,
    output logic       branch_type_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_BEQ   = 4'b0011;
    localparam logic [3:0] ALU_BNE   = 4'b0001;
    localparam logic [3:0] ALU_SLTIU = 4'b0111;
    localparam logic [3:0] ALU_LUI   = 4'b0101;
    localparam logic [3:0] ALU_ORI   = 4'b0110;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic             TMO_EN    = (MEM_TIMEOUT != 0);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ALU_WB = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op_q;
    logic [CNT_W-1:0] r_wait;
    logic             w_is_mem;
    logic             w_timeout;
    logic             w_op_legal;
    logic             w_is_beq;

    always_comb begin
        w_is_mem  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        // Ready takes priority: a timeout only fires while ready is still low.
        w_timeout = TMO_EN && w_is_mem && !mem_ready_i && (r_wait == TIMEOUT_C);
        w_is_beq  = (r_op_q == OP_BEQ);
        case (opcode_i)
            OP_RTYPE, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: w_op_legal = 1'b1;
            default:                                     w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FETCH;
            r_op_q  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= opcode_i;
            end
            // Count only while waiting in place; any completion, timeout or exit clears it.
            if (w_is_mem && !mem_ready_i && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready_i) w_next = S_DECODE;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                         w_next = S_EXEC_R;
                    OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:                     w_next = S_ADDR;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J, OP_JAL:                     w_next = S_JUMP;
                    default:                          w_next = S_FETCH;
                endcase
            end
            S_EXEC_R: w_next = S_ALU_WB;
            S_EXEC_I: w_next = S_ALU_WB;
            S_ALU_WB: w_next = S_FETCH;
            S_ADDR:   w_next = (r_op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i) w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_FETCH;
            end
            S_MEM_WB: w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready_i || w_timeout) w_next = S_FETCH;
            end
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_o    = 1'b0;
        ir_write_o    = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        iord_o        = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        alu_op_o      = 4'b0000;
        reg_write_o   = 1'b0;
        reg_dst_o     = 2'b00;
        mem_to_reg_o  = 2'b00;
        pc_src_o      = 2'b00;
        branch_o      = 1'b0;
        branch_type_o = 1'b0;
        instr_done_o  = 1'b0;
        illegal_o     = 1'b0;
        bus_err_o     = 1'b0;
        state_o       = r_state;

        case (r_state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                alu_op_o    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                bus_err_o   = w_timeout;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                alu_op_o    = ALU_ADD;
                illegal_o   = !w_op_legal;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (r_op_q)
                    OP_SLTIU: alu_op_o = ALU_SLTIU;
                    OP_LUI:   alu_op_o = ALU_LUI;
                    OP_ORI:   alu_op_o = ALU_ORI;
                    default:  alu_op_o = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = (r_op_q == OP_RTYPE) ? 2'b01 : 2'b00;
                instr_done_o = 1'b1;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                bus_err_o = w_timeout;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
                instr_done_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
                bus_err_o    = w_timeout;
            end
            S_BRANCH: begin
                alu_src_a_o   = 1'b1;
                branch_o      = 1'b1;
                pc_src_o      = 2'b01;
                branch_type_o = w_is_beq;
                alu_op_o      = w_is_beq ? ALU_BEQ : ALU_BNE;
                pc_write_o    = w_is_beq ? zero_i : !zero_i;
                instr_done_o  = 1'b1;
            end
            S_JUMP: begin
                pc_src_o     = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                if (r_op_q == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'b10;
                    mem_to_reg_o = 2'b10;
                end
            end
            default: ;
        endcase

        if (rst_i) begin
            pc_write_o    = 1'b0;
            ir_write_o    = 1'b0;
            mem_req_o     = 1'b0;
            mem_we_o      = 1'b0;
            iord_o        = 1'b0;
            alu_src_a_o   = 1'b0;
            alu_src_b_o   = 2'b00;
            alu_op_o      = 4'b0000;
            reg_write_o   = 1'b0;
            reg_dst_o     = 2'b00;
            mem_to_reg_o  = 2'b00;
            pc_src_o      = 2'b00;
            branch_o      = 1'b0;
            branch_type_o = 1'b0;
            instr_done_o  = 1'b0;
            illegal_o     = 1'b0;
            bus_err_o     = 1'b0;
            state_o       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: expected per-cycle output vectors are queued
// with their stimulus, then drained and compared one cycle at a time.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_req, mem_we, iord, alu_src_a;
    logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
    logic [3:0] alu_op, state;
    logic       reg_write, branch, branch_type, instr_done, illegal, bus_err;
    logic [27:0] w_obs;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .ir_write_o(ir_write), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .iord_o(iord), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
        .pc_src_o(pc_src), .branch_o(branch), .branch_type_o(branch_type),
        .instr_done_o(instr_done), .illegal_o(illegal), .bus_err_o(bus_err), .state_o(state)
    );

    assign w_obs = {state, pc_write, ir_write, mem_req, mem_we, iord, alu_src_a, alu_src_b,
                    alu_op, reg_write, reg_dst, mem_to_reg, pc_src, branch, branch_type,
                    instr_done, illegal, bus_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [27:0] exp;
    } step_t;

    step_t sb[$];

    function automatic logic [27:0] ev(
        input logic [3:0] st, input logic pcw, input logic irw, input logic req,
        input logic we, input logic io, input logic sa, input logic [1:0] sbv,
        input logic [3:0] aop, input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
        input logic [1:0] pcs, input logic br, input logic bt, input logic dn,
        input logic ill, input logic be);
        return {st, pcw, irw, req, we, io, sa, sbv, aop, rw, rd, m2r, pcs, br, bt, dn, ill, be};
    endfunction

    function automatic logic [27:0] e_fetch(input logic r, input logic be);
        return ev(4'd0, r, r, 1, 0, 0, 0, 2'b01, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, be);
    endfunction
    function automatic logic [27:0] e_decode(input logic ill);
        return ev(4'd1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, ill, 0);
    endfunction
    function automatic logic [27:0] e_exec_r();
        return ev(4'd2, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [27:0] e_exec_i(input logic [3:0] aop);
        return ev(4'd3, 0, 0, 0, 0, 0, 1, 2'b10, aop, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [27:0] e_alu_wb(input logic [1:0] rd);
        return ev(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, rd, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [27:0] e_addr();
        return ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0100, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [27:0] e_mem_rd(input logic be);
        return ev(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, be);
    endfunction
    function automatic logic [27:0] e_mem_wb();
        return ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [27:0] e_mem_wr(input logic r, input logic be);
        return ev(4'd7, 0, 0, 1, 1, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0, 0, r, 0, be);
    endfunction
    function automatic logic [27:0] e_branch(input logic is_beq, input logic z);
        return ev(4'd8, is_beq ? z : !z, 0, 0, 0, 0, 1, 2'b00, is_beq ? 4'b0011 : 4'b0001,
                  0, 2'b00, 2'b00, 2'b01, 1, is_beq, 1, 0, 0);
    endfunction
    function automatic logic [27:0] e_jump(input logic is_jal);
        return ev(4'd9, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, is_jal, is_jal ? 2'b10 : 2'b00,
                  is_jal ? 2'b10 : 2'b00, 2'b10, 0, 0, 1, 0, 0);
    endfunction

    task automatic push_step(input logic r, input logic z, input logic [5:0] op, input logic [27:0] e);
        step_t s;
        s.rst = 1'b0; s.rdy = r; s.zero = z; s.op = op; s.exp = e;
        sb.push_back(s);
    endtask

    // Non-memory, non-branch cycle: ready, zero and opcode must not matter.
    task automatic push_any(input logic [27:0] e);
        push_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom), e);
    endtask

    task automatic push_rst();
        step_t s;
        s.rst = 1'b1; s.rdy = 1'($urandom_range(0, 1)); s.zero = 1'b0;
        s.op = 6'($urandom); s.exp = '0;
        sb.push_back(s);
    endtask

    // Full expected sequence of one instruction: fw fetch waits, mw memory waits.
    task automatic push_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push_step(0, 1'($urandom_range(0, 1)), 6'($urandom), e_fetch(0, 0));
        push_step(1, 1'($urandom_range(0, 1)), 6'($urandom), e_fetch(1, 0));
        case (op)
            6'b000000: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                push_any(e_exec_r());
                push_any(e_alu_wb(2'b01));
            end
            6'b001000, 6'b001011, 6'b001111, 6'b001101: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                case (op)
                    6'b001011: push_any(e_exec_i(4'b0111));
                    6'b001111: push_any(e_exec_i(4'b0101));
                    6'b001101: push_any(e_exec_i(4'b0110));
                    default:   push_any(e_exec_i(4'b0100));
                endcase
                push_any(e_alu_wb(2'b00));
            end
            6'b100011: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                push_any(e_addr());
                for (int i = 0; i < mw; i++) push_step(0, 1'($urandom_range(0, 1)), 6'($urandom), e_mem_rd(0));
                push_step(1, 1'($urandom_range(0, 1)), 6'($urandom), e_mem_rd(0));
                push_any(e_mem_wb());
            end
            6'b101011: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                push_any(e_addr());
                for (int i = 0; i < mw; i++) push_step(0, 1'($urandom_range(0, 1)), 6'($urandom), e_mem_wr(0, 0));
                push_step(1, 1'($urandom_range(0, 1)), 6'($urandom), e_mem_wr(1, 0));
            end
            6'b000100, 6'b000101: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                push_step(1'($urandom_range(0, 1)), z, 6'($urandom), e_branch(op == 6'b000100, z));
            end
            6'b000010, 6'b000011: begin
                push_step(1'($urandom_range(0, 1)), 0, op, e_decode(0));
                push_any(e_jump(op == 6'b000011));
            end
            default: push_step(1'($urandom_range(0, 1)), 0, op, e_decode(1));
        endcase
    endtask

    task automatic test_reset();
        step_t s;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1; mem_ready = 1'b1; opcode = 6'($urandom); zero = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (w_obs !== 28'd0) begin
                failures++;
                $display("FAIL reset[%0d] got=%h expected=%h", i, w_obs, 28'd0);
            end
        end
        push_step(1, 0, 6'd0, e_fetch(1, 0));
        push_step(1, 0, 6'b001101, e_decode(0));
        push_step(1, 0, 6'd0, e_exec_i(4'b0110));
        push_step(1, 0, 6'd0, e_alu_wb(2'b00));
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL reset_release[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_alu_instrs();
        step_t s;
        int n = 0;
        push_instr(6'b000000, 0, 0, 0);
        push_instr(6'b001000, 0, 0, 0);
        push_instr(6'b001011, 0, 0, 0);
        push_instr(6'b001111, 0, 1, 0);
        push_instr(6'b001101, 0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL alu_instrs[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_mem_instrs();
        step_t s;
        int n = 0;
        push_instr(6'b100011, 0, 0, 3);
        push_instr(6'b100011, 0, 0, 0);
        push_instr(6'b101011, 0, 0, 0);
        push_instr(6'b101011, 0, 2, 5);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL mem_instrs[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_branch_jump();
        step_t s;
        int n = 0;
        push_instr(6'b000100, 1, 0, 0);
        push_instr(6'b000101, 1, 0, 0);
        push_instr(6'b000100, 0, 0, 0);
        push_instr(6'b000101, 0, 0, 0);
        push_instr(6'b000011, 0, 0, 0);
        push_instr(6'b000010, 0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL branch_jump[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_illegal();
        step_t s;
        int n = 0;
        push_instr(6'b111111, 0, 0, 0);
        push_instr(6'b000001, 0, 0, 0);
        push_instr(6'b100000, 0, 0, 0);
        push_instr(6'b000000, 0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL illegal[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        step_t s;
        int n = 0;
        // sw with ready held low: 16 plain wait cycles, bus error on the 17th.
        push_step(1, 0, 6'd0, e_fetch(1, 0));
        push_step(1, 0, 6'b101011, e_decode(0));
        push_any(e_addr());
        for (int i = 0; i < 16; i++) push_step(0, 0, 6'd0, e_mem_wr(0, 0));
        push_step(0, 0, 6'd0, e_mem_wr(0, 1));
        // Ready on the timeout cycle completes normally.
        push_instr(6'b101011, 0, 0, 16);
        // lw read timeout, then fetch timeout, then fetch ready on the timeout cycle.
        push_step(1, 0, 6'd0, e_fetch(1, 0));
        push_step(1, 0, 6'b100011, e_decode(0));
        push_any(e_addr());
        for (int i = 0; i < 16; i++) push_step(0, 0, 6'd0, e_mem_rd(0));
        push_step(0, 0, 6'd0, e_mem_rd(1));
        for (int i = 0; i < 16; i++) push_step(0, 0, 6'd0, e_fetch(0, 0));
        push_step(0, 0, 6'd0, e_fetch(0, 1));
        push_instr(6'b000000, 0, 16, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL timeout[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        int n = 0;
        push_step(1, 0, 6'd0, e_fetch(1, 0));
        push_step(1, 0, 6'b100011, e_decode(0));
        push_any(e_addr());
        push_step(0, 0, 6'd0, e_mem_rd(0));
        push_step(0, 0, 6'd0, e_mem_rd(0));
        push_rst();
        // Wait counter and op_q must restart clean: 16 fetch waits stay error-free.
        push_instr(6'b001011, 0, 16, 0);
        push_step(1, 0, 6'd0, e_fetch(1, 0));
        push_step(1, 0, 6'b000011, e_decode(0));
        push_rst();
        push_instr(6'b000010, 0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int n = 0;
        logic [5:0] ops [14];
        ops = '{6'b000000, 6'b001000, 6'b001011, 6'b001111, 6'b001101, 6'b100011, 6'b101011,
                6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b111111, 6'b010000, 6'b110001};
        for (int i = 0; i < 40; i++) begin
            push_instr(ops[$urandom_range(0, 13)], 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        while (sb.size() != 0) begin
            s = sb.pop_front();
            @(negedge clk);
            rst = s.rst; mem_ready = s.rdy; zero = s.zero; opcode = s.op;
            #1;
            checks++;
            if (w_obs !== s.exp) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h expected=%h", n, w_obs, s.exp);
            end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
        test_reset();
        test_alu_instrs();
        test_mem_instrs();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
